// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package cla_pkg;

    localparam int CLA_DEFAULT_WIDTH = 3;
    localparam int CLA_DEFAULT_GROUP = 4;

    // Number of lookahead groups; the top group may be narrower than grp.
    function automatic int cla_num_groups(input int n, input int grp);
        return (n + grp - 1) / grp;
    endfunction

endpackage

// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder. With CLA_OVF_EN defined, carries the
// signed-overflow flag alongside the sum.
interface cla_adder_if #(parameter int N = cla_pkg::CLA_DEFAULT_WIDTH);

    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] y;
    logic         cout;
    logic         out_valid;
`ifdef CLA_OVF_EN
    logic         ovf;

    modport master (output in_valid, a, b, cin, input y, cout, out_valid, ovf);
    modport slave  (input in_valid, a, b, cin, output y, cout, out_valid, ovf);
`else
    modport master (output in_valid, a, b, cin, input y, cout, out_valid);
    modport slave  (input in_valid, a, b, cin, output y, cout, out_valid);
`endif

endinterface

// File: rtl/cla_adder_group.sv
// One lookahead group of up to GROUP bits: flat sum-of-products carries,
// group generate/propagate, and the sum slice.
module cla_group #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         g_grp,
    output logic         p_grp,
    output logic [W-1:0] c
);

    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Carry into bit i: OR of every generate term propagated up to i, plus
    // ci propagated through all lower bits. Unrolls to a two-level SOP.
    function automatic logic carry_into(input logic [W-1:0] gv, input logic [W-1:0] pv,
                                        input logic ci, input int i);
        logic acc;
        logic term;
        term = ci;
        for (int k = 0; k < i; k++) term &= pv[k];
        acc = term;
        for (int j = 0; j < i; j++) begin
            term = gv[j];
            for (int k = j + 1; k < i; k++) term &= pv[k];
            acc |= term;
        end
        return acc;
    endfunction

    always_comb begin
        c = '0;
        for (int i = 0; i < W; i++) c[i] = carry_into(g, p, cin, i);
    end

    assign g_grp = carry_into(g, p, 1'b0, W);
    assign p_grp = &p;
    assign s     = p ^ c;

endmodule

// File: rtl/cla_adder.sv
// Registered N-bit carry-lookahead adder built from GROUP-bit lookahead blocks.
// Optional macro CLA_OVF_EN adds a registered two's-complement overflow flag.
module cla_adder
    import cla_pkg::*;
#(
    parameter int N     = CLA_DEFAULT_WIDTH,
    parameter int GROUP = CLA_DEFAULT_GROUP
) (
    input  logic        clk,
    input  logic        rst,
    cla_adder_if.slave  io
);

    localparam int NG = cla_num_groups(N, GROUP);

    logic [NG:0]   cg;
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [N-1:0]  sum;
    logic [N-1:0]  carry_all;

    assign cg[0] = io.cin;

    // Only group-level G/P ripple between groups, so depth scales with N/GROUP.
    for (genvar j = 0; j < NG; j++) begin : g_grp
        localparam int LO = j * GROUP;
        localparam int W  = (N - LO < GROUP) ? (N - LO) : GROUP;

        cla_group #(.W(W)) u_grp (
            .a     (io.a[LO +: W]),
            .b     (io.b[LO +: W]),
            .cin   (cg[j]),
            .s     (sum[LO +: W]),
            .g_grp (gg[j]),
            .p_grp (pg[j]),
            .c     (carry_all[LO +: W])
        );

        assign cg[j+1] = gg[j] | (pg[j] & cg[j]);
    end

    logic [N-1:0] y_q;
    logic         cout_q;
    logic         vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= io.in_valid;
            if (io.in_valid) begin
                y_q    <= sum;
                cout_q <= cg[NG];
            end
        end
    end

    assign io.y         = y_q;
    assign io.cout      = cout_q;
    assign io.out_valid = vld_q;

`ifdef CLA_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              ovf_q <= 1'b0;
        else if (io.in_valid) ovf_q <= cg[NG] ^ carry_all[N-1];
    end

    assign io.ovf = ovf_q;
`else
    logic unused_carries;
    assign unused_carries = ^carry_all;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Directed and model-based checks of cla_adder at N=3, 8 and 13 (GROUP=4).
module tb_cla_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_adder_if #(.N(3))  b3 ();
    cla_adder_if #(.N(8))  b8 ();
    cla_adder_if #(.N(13)) b13 ();

    cla_adder #(.N(3),  .GROUP(4)) u_dut3  (.clk(clk), .rst(rst), .io(b3.slave));
    cla_adder #(.N(8),  .GROUP(4)) u_dut8  (.clk(clk), .rst(rst), .io(b8.slave));
    cla_adder #(.N(13), .GROUP(4)) u_dut13 (.clk(clk), .rst(rst), .io(b13.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Directed N=3 vector with hand-computed result; ovf checked when present.
    task automatic dir3(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic c, input logic [2:0] ey, input logic ec, input logic eo);
        @(negedge clk);
        b3.a = a; b3.b = b; b3.cin = c; b3.in_valid = 1'b1;
        @(negedge clk);
        b3.in_valid = 1'b0;
        chk({tag, ".y"}, 32'(b3.y), 32'(ey));
        chk({tag, ".cout"}, 32'(b3.cout), 32'(ec));
        chk({tag, ".vld"}, 32'(b3.out_valid), 32'd1);
`ifdef CLA_OVF_EN
        chk({tag, ".ovf"}, 32'(b3.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
    endtask

    // Model-based N=3 vector for the exhaustive sweep.
    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic c);
        logic [3:0] s;
        logic [2:0] lo;
        s  = 4'(a) + 4'(b) + 4'(c);
        lo = 3'(a[1:0]) + 3'(b[1:0]) + 3'(c);
        @(negedge clk);
        b3.a = a; b3.b = b; b3.cin = c; b3.in_valid = 1'b1;
        @(negedge clk);
        b3.in_valid = 1'b0;
        chk($sformatf("ex3 %0d+%0d+%0d y", a, b, c), 32'(b3.y), 32'(s[2:0]));
        chk($sformatf("ex3 %0d+%0d+%0d cout", a, b, c), 32'(b3.cout), 32'(s[3]));
`ifdef CLA_OVF_EN
        chk($sformatf("ex3 %0d+%0d+%0d ovf", a, b, c), 32'(b3.ovf), 32'(s[3] ^ lo[2]));
`endif
    endtask

    initial begin
        b3.in_valid = 0;  b3.a = '0;  b3.b = '0;  b3.cin = 0;
        b8.in_valid = 0;  b8.a = '0;  b8.b = '0;  b8.cin = 0;
        b13.in_valid = 0; b13.a = '0; b13.b = '0; b13.cin = 0;

        #3;
        chk("rst.y", 32'(b3.y), 32'd0);
        chk("rst.cout", 32'(b3.cout), 32'd0);
        chk("rst.vld", 32'(b3.out_valid), 32'd0);
        chk("rst.y13", 32'(b13.y), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.vld", 32'(b3.out_valid), 32'd0);

        dir3("d_2_3_0", 3'd2, 3'd3, 1'b0, 3'd5, 1'b0, 1'b1);
        dir3("d_2_4_1", 3'd2, 3'd4, 1'b1, 3'd7, 1'b0, 1'b0);
        dir3("d_5_4_0", 3'd5, 3'd4, 1'b0, 3'd1, 1'b1, 1'b1);
        dir3("d_5_4_1", 3'd5, 3'd4, 1'b1, 3'd2, 1'b1, 1'b1);
        dir3("d_7_7_1", 3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0);
        dir3("d_7_0_1", 3'd7, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
        dir3("d_3_1_0", 3'd3, 3'd1, 1'b0, 3'd4, 1'b0, 1'b1);

        // Idle cycle: out_valid drops, result holds.
        @(negedge clk);
        chk("hold.vld", 32'(b3.out_valid), 32'd0);
        chk("hold.y", 32'(b3.y), 32'd4);
        chk("hold.cout", 32'(b3.cout), 32'd0);

        for (int i = 0; i < 128; i++) run3(3'(i), 3'(i >> 3), i[6]);

        // Random N=8 / N=13 stream with in_valid toggling; expectations lag one cycle.
        begin
            logic [7:0]  ey8,  a8,  bb8;
            logic [12:0] ey13, a13, bb13;
            logic        ec8, ev8, eo8, ec13, ev13, eo13, c8, c13, v;
            logic [8:0]  s8;
            logic [13:0] s13;
            logic [7:0]  l8;
            logic [12:0] l13;
            ey8 = '0; ec8 = 0; ev8 = 0; eo8 = 0;
            ey13 = '0; ec13 = 0; ev13 = 0; eo13 = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                chk($sformatf("r8[%0d].y", i), 32'(b8.y), 32'(ey8));
                chk($sformatf("r8[%0d].cout", i), 32'(b8.cout), 32'(ec8));
                chk($sformatf("r8[%0d].vld", i), 32'(b8.out_valid), 32'(ev8));
                chk($sformatf("r13[%0d].y", i), 32'(b13.y), 32'(ey13));
                chk($sformatf("r13[%0d].cout", i), 32'(b13.cout), 32'(ec13));
                chk($sformatf("r13[%0d].vld", i), 32'(b13.out_valid), 32'(ev13));
`ifdef CLA_OVF_EN
                chk($sformatf("r8[%0d].ovf", i), 32'(b8.ovf), 32'(eo8));
                chk($sformatf("r13[%0d].ovf", i), 32'(b13.ovf), 32'(eo13));
`endif
                a8 = 8'($urandom); bb8 = 8'($urandom); c8 = 1'($urandom);
                a13 = 13'($urandom); bb13 = 13'($urandom); c13 = 1'($urandom);
                v = 1'($urandom_range(0, 1));
                if (i == 0) begin
                    a8 = '1; bb8 = '1; c8 = 1; a13 = '1; bb13 = '1; c13 = 1; v = 1;
                end else if (i == 1) begin
                    a8 = '1; bb8 = '0; c8 = 1; a13 = '1; bb13 = '0; c13 = 1; v = 1;
                end
                b8.a = a8;   b8.b = bb8;   b8.cin = c8;   b8.in_valid = v;
                b13.a = a13; b13.b = bb13; b13.cin = c13; b13.in_valid = v;
                ev8 = v; ev13 = v;
                if (v) begin
                    s8  = 9'(a8) + 9'(bb8) + 9'(c8);
                    s13 = 14'(a13) + 14'(bb13) + 14'(c13);
                    l8  = 8'(a8[6:0]) + 8'(bb8[6:0]) + 8'(c8);
                    l13 = 13'(a13[11:0]) + 13'(bb13[11:0]) + 13'(c13);
                    ey8 = s8[7:0];    ec8 = s8[8];    eo8 = s8[8] ^ l8[7];
                    ey13 = s13[12:0]; ec13 = s13[13]; eo13 = s13[13] ^ l13[12];
                end
            end
            @(negedge clk);
            b8.in_valid = 0; b13.in_valid = 0;
        end

        // Asynchronous reset mid-cycle discards the held result.
        @(negedge clk);
        b3.a = 3'd6; b3.b = 3'd3; b3.cin = 0; b3.in_valid = 1;
        @(posedge clk);
        #2;
        chk("pre_rst.y", 32'(b3.y), 32'd1);
        chk("pre_rst.cout", 32'(b3.cout), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst.y", 32'(b3.y), 32'd0);
        chk("async_rst.cout", 32'(b3.cout), 32'd0);
        chk("async_rst.vld", 32'(b3.out_valid), 32'd0);
        @(negedge clk);
        b3.in_valid = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.vld", 32'(b3.out_valid), 32'd0);
        chk("post_rst.y", 32'(b3.y), 32'd0);
        b3.a = 3'd1; b3.b = 3'd1; b3.cin = 0; b3.in_valid = 1;
        @(negedge clk);
        b3.in_valid = 0;
        chk("first.y", 32'(b3.y), 32'd2);
        chk("first.vld", 32'(b3.out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
